// File: rtl/perm_pkg.sv
// Shared constants and helpers for the Keccak-f[1600] permutation datapath.
// Flat state bit index is 64*(5*y+x)+z; chunk k covers state bits [200*k+199 : 200*k].
package perm_pkg;

  localparam int STATE_W = 1600;
  localparam int CHUNK_W = 200;
  localparam int NCHUNK  = 8;
  localparam int LANE_W  = 64;
  localparam int DIX_W   = $clog2(NCHUNK);

  typedef logic [CHUNK_W-1:0] chunk_t;
  typedef logic [STATE_W-1:0] state_t;
  typedef logic [NCHUNK-1:0]  chunk_mask_t;

  function automatic int lane_idx(input int x, input int y);
    return 5 * y + x;
  endfunction

endpackage

// File: rtl/perm_chunk_buf.sv
// One 1600-bit assembly buffer with its received-chunk mask and full flag.
// Writes are ignored while full; clr only ever arrives while full.
module perm_chunk_buf
  import perm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [DIX_W-1:0] wr_dix,
  input  chunk_t           wr_data,
  input  logic             clr,
  output state_t           data,
  output chunk_mask_t      mask,
  output logic             full,
  output logic             done,
  output logic             dup
);

  state_t      data_q, data_d;
  chunk_mask_t mask_q, mask_d;
  logic        full_q, full_d;
  chunk_mask_t set_mask;

  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    full_d   = full_q;
    done     = 1'b0;
    dup      = 1'b0;
    set_mask = mask_q | (chunk_mask_t'(1) << wr_dix);
    if (wr_en && !full_q) begin
      data_d[CHUNK_W*wr_dix +: CHUNK_W] = wr_data;
      // A repeated chunk refreshes data but never completes the buffer
      if (mask_q[wr_dix]) begin
        dup = 1'b1;
      end else if (&set_mask) begin
        full_d = 1'b1;
        mask_d = '0;
        done   = 1'b1;
      end else begin
        mask_d = set_mask;
      end
    end
    if (clr) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      mask_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      full_q <= full_d;
    end
  end

  assign data = data_q;
  assign mask = mask_q;
  assign full = full_q;

endmodule

// File: rtl/perm_in_assembler.sv
// Ping-pong assembler: gathers eight 200-bit chunks into a 1600-bit state and
// offers it to the permutation engine over valid/ready while the other buffer refills.
module perm_in_assembler
  import perm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [DIX_W-1:0]   dix,
  input  logic [CHUNK_W-1:0] din,
  input  logic               pushin,
  input  logic               state_ready,
  output logic               state_valid,
  output logic [STATE_W-1:0] state_out,
  output logic               busy,
  output logic               dup_err,
  output logic               overflow
);

  logic wr_sel_q, wr_sel_d;
  logic rd_sel_q, rd_sel_d;
  logic dup_err_q, dup_err_d;
  logic overflow_q, overflow_d;
  logic consume;

  state_t      buf_data [2];
  chunk_mask_t buf_mask [2];
  logic        buf_full [2];
  logic        buf_done [2];
  logic        buf_dup  [2];
  logic        buf_wr   [2];
  logic        buf_clr  [2];

  assign consume = buf_full[rd_sel_q] && state_ready;

  for (genvar g = 0; g < 2; g++) begin : g_buf
    assign buf_wr[g]  = pushin && (wr_sel_q == 1'(g));
    assign buf_clr[g] = consume && (rd_sel_q == 1'(g));

    perm_chunk_buf u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (buf_wr[g]),
      .wr_dix  (dix),
      .wr_data (din),
      .clr     (buf_clr[g]),
      .data    (buf_data[g]),
      .mask    (buf_mask[g]),
      .full    (buf_full[g]),
      .done    (buf_done[g]),
      .dup     (buf_dup[g])
    );
  end

  // Completion and consumption may land on the same edge; each select flips independently
  always_comb begin
    wr_sel_d   = wr_sel_q ^ (buf_done[0] | buf_done[1]);
    rd_sel_d   = rd_sel_q ^ consume;
    dup_err_d  = buf_dup[0] | buf_dup[1];
    overflow_d = overflow_q | (pushin && buf_full[wr_sel_q]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      dup_err_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      dup_err_q  <= dup_err_d;
      overflow_q <= overflow_d;
    end
  end

  assign state_valid = buf_full[rd_sel_q];
  assign state_out   = buf_data[rd_sel_q];
  assign busy        = |buf_mask[wr_sel_q];
  assign dup_err     = dup_err_q;
  assign overflow    = overflow_q;

endmodule
